// File: rtl/sha2_pkg.sv
// Shared types, round constants, initial hash values and round functions for
// the SHA-224/256/384/512 compression core.
package sha2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HASH  = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } sha2_fsm_e;

   localparam logic [31:0] K256 [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [63:0] K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   // H0..H7 packed with H0 in the MSBs
   localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
   localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] IV384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                                     64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
   localparam logic [511:0] IV512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                     64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   // 32-bit variants come back in the low 256 bits
   function automatic logic [511:0] iv_for(input int dw);
      case (dw)
         224:     return {256'h0, IV224};
         256:     return {256'h0, IV256};
         384:     return IV384;
         default: return IV512;
      endcase
   endfunction

   // 32-bit words travel in the low half; the upper half is ignored on input
   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
      logic [31:0] x32;
      x32 = x[31:0];
      if (ww == 32) return {32'h0, (x32 >> n) | (x32 << (32 - n))};
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] shr(input logic [63:0] x, input int n, input int ww);
      logic [31:0] x32;
      x32 = x[31:0];
      if (ww == 32) return {32'h0, x32 >> n};
      return x >> n;
   endfunction

   function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int ww);
      if (ww == 32) return rotr(x, 2, ww) ^ rotr(x, 13, ww) ^ rotr(x, 22, ww);
      return rotr(x, 28, ww) ^ rotr(x, 34, ww) ^ rotr(x, 39, ww);
   endfunction

   function automatic logic [63:0] big_sigma1(input logic [63:0] x, input int ww);
      if (ww == 32) return rotr(x, 6, ww) ^ rotr(x, 11, ww) ^ rotr(x, 25, ww);
      return rotr(x, 14, ww) ^ rotr(x, 18, ww) ^ rotr(x, 41, ww);
   endfunction

   function automatic logic [63:0] small_sigma0(input logic [63:0] x, input int ww);
      if (ww == 32) return rotr(x, 7, ww) ^ rotr(x, 18, ww) ^ shr(x, 3, ww);
      return rotr(x, 1, ww) ^ rotr(x, 8, ww) ^ shr(x, 7, ww);
   endfunction

   function automatic logic [63:0] small_sigma1(input logic [63:0] x, input int ww);
      if (ww == 32) return rotr(x, 17, ww) ^ rotr(x, 19, ww) ^ shr(x, 10, ww);
      return rotr(x, 19, ww) ^ rotr(x, 61, ww) ^ shr(x, 6, ww);
   endfunction

   function automatic logic [63:0] ch(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// 16-word sliding message schedule window; w_o is W[t] for the current round.
module sha2_msg_sched
   import sha2_pkg::*;
#(
   parameter int WordWidth = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      load_i,
   input  logic                      advance_i,
   input  logic [16*WordWidth-1:0]   block_i,
   output logic [WordWidth-1:0]      w_o
);

   logic [WordWidth-1:0] win_q [16];
   logic [WordWidth-1:0] win_d [16];
   logic [WordWidth-1:0] w_next;

   // W[t+16] from W[t+14], W[t+9], W[t+1], W[t]
   always_comb begin
      w_next = WordWidth'(small_sigma1(64'(win_q[14]), WordWidth)) + win_q[9]
             + WordWidth'(small_sigma0(64'(win_q[1]), WordWidth)) + win_q[0];
   end

   // load a fresh block (word 0 from the MSBs) or slide the window by one word
   always_comb begin
      win_d = win_q;
      if (load_i) begin
         for (int i = 0; i < 16; i++) begin
            win_d[i] = block_i[16*WordWidth-1-WordWidth*i -: WordWidth];
         end
      end else if (advance_i) begin
         for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[15] = w_next;
      end
   end

   // window storage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         win_q <= win_d;
      end
   end

   assign w_o = win_q[0];

endmodule

// File: rtl/sha2_core.sv
// SHA-2 compression engine: block handshake, round datapath, chaining values.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a block; H holds IV or chaining value
// ST_HASH  | one compression round per cycle
// ST_FINAL | fold working variables into H
// ST_DONE  | digest valid; a new block restarts from the IV
module sha2_core
   import sha2_pkg::*;
#(
   parameter  int DigestWidth = 256,
   localparam int WordWidth   = (DigestWidth > 256) ? 64 : 32,
   localparam int BlockWidth  = 16 * WordWidth,
   localparam int Rounds      = (WordWidth == 64) ? 80 : 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   init_i,
   input  logic [BlockWidth-1:0]  block_i,
   input  logic                   block_valid_i,
   input  logic                   block_last_i,
   output logic                   block_ready_o,
   output logic                   busy_o,
   output logic [6:0]             round_o,
   output logic [DigestWidth-1:0] digest_o,
   output logic                   digest_valid_o
);

   if (DigestWidth != 224 && DigestWidth != 256 && DigestWidth != 384 && DigestWidth != 512) begin : g_bad_width
      $error("sha2_core: unsupported DigestWidth %0d", DigestWidth);
   end

   localparam int              HW        = 8 * WordWidth;
   localparam logic [HW-1:0]   IvInit    = HW'(iv_for(DigestWidth));
   localparam logic [6:0]      LastRound = 7'(Rounds - 1);

   typedef logic [WordWidth-1:0] word_t;

   sha2_fsm_e              state_q, state_d;
   logic [6:0]             round_q, round_d;
   word_t                  h_q [8];
   word_t                  h_d [8];
   word_t                  wv_q [8];
   word_t                  wv_d [8];
   logic                   last_q, last_d;
   logic [DigestWidth-1:0] digest_q, digest_d;
   logic [HW-1:0]          h_sum;
   logic                   hs;
   word_t                  w_t, k_t, t1, t2;

   function automatic word_t iv_word(input int i);
      return IvInit[HW-1-WordWidth*i -: WordWidth];
   endfunction

   if (WordWidth == 64) begin : g_k64
      assign k_t = K512[round_q];
   end else begin : g_k32
      assign k_t = K256[round_q[5:0]];
   end

   sha2_msg_sched #(.WordWidth(WordWidth)) u_sched (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (hs),
      .advance_i (state_q == ST_HASH),
      .block_i   (block_i),
      .w_o       (w_t)
   );

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // next state; init_i wins over everything
   always_comb begin
      state_d = state_q;
      if (init_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (hs) state_d = ST_HASH;
            ST_HASH:          if (round_q == LastRound) state_d = ST_FINAL;
            ST_FINAL:         state_d = last_q ? ST_DONE : ST_IDLE;
            default:          state_d = ST_IDLE;
         endcase
      end
   end

   // handshake and status outputs
   always_comb begin
      block_ready_o  = 1'b0;
      busy_o         = 1'b0;
      digest_valid_o = 1'b0;
      case (state_q)
         ST_IDLE:            block_ready_o = ~init_i;
         ST_DONE: begin
            block_ready_o  = ~init_i;
            digest_valid_o = 1'b1;
         end
         ST_HASH, ST_FINAL:  busy_o = 1'b1;
         default:            ;
      endcase
   end

   assign hs = block_valid_i & block_ready_o;

   // chaining value plus working variables, H0 in the MSBs
   always_comb begin
      h_sum = '0;
      for (int i = 0; i < 8; i++) begin
         h_sum[HW-1-WordWidth*i -: WordWidth] = h_q[i] + wv_q[i];
      end
   end

   // round datapath, chaining update and digest capture
   always_comb begin
      round_d  = round_q;
      h_d      = h_q;
      wv_d     = wv_q;
      last_d   = last_q;
      digest_d = digest_q;
      t1 = wv_q[7] + WordWidth'(big_sigma1(64'(wv_q[4]), WordWidth))
         + WordWidth'(ch(64'(wv_q[4]), 64'(wv_q[5]), 64'(wv_q[6]))) + k_t + w_t;
      t2 = WordWidth'(big_sigma0(64'(wv_q[0]), WordWidth))
         + WordWidth'(maj(64'(wv_q[0]), 64'(wv_q[1]), 64'(wv_q[2])));
      if (init_i) begin
         round_d = '0;
         for (int i = 0; i < 8; i++) h_d[i] = iv_word(i);
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (hs) begin
                  round_d = '0;
                  last_d  = block_last_i;
                  for (int i = 0; i < 8; i++) begin
                     // a block accepted from DONE opens a new message
                     if (state_q == ST_DONE) begin
                        h_d[i]  = iv_word(i);
                        wv_d[i] = iv_word(i);
                     end else begin
                        wv_d[i] = h_q[i];
                     end
                  end
               end
            end
            ST_HASH: begin
               round_d = (round_q == LastRound) ? 7'd0 : round_q + 7'd1;
               wv_d[7] = wv_q[6];
               wv_d[6] = wv_q[5];
               wv_d[5] = wv_q[4];
               wv_d[4] = wv_q[3] + t1;
               wv_d[3] = wv_q[2];
               wv_d[2] = wv_q[1];
               wv_d[1] = wv_q[0];
               wv_d[0] = t1 + t2;
            end
            ST_FINAL: begin
               for (int i = 0; i < 8; i++) h_d[i] = h_sum[HW-1-WordWidth*i -: WordWidth];
               if (last_q) digest_d = h_sum[HW-1 -: DigestWidth];
            end
            default: ;
         endcase
      end
   end

   // datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         round_q  <= '0;
         last_q   <= 1'b0;
         digest_q <= '0;
         for (int i = 0; i < 8; i++) begin
            h_q[i]  <= iv_word(i);
            wv_q[i] <= '0;
         end
      end else begin
         round_q  <= round_d;
         last_q   <= last_d;
         digest_q <= digest_d;
         h_q      <= h_d;
         wv_q     <= wv_d;
      end
   end

   assign round_o  = round_q;
   assign digest_o = digest_q;

endmodule

// File: tb/tb_sha2_core.sv
// Bench for sha2_core: all four digest widths, multi-block, abort and reset.
module tb_sha2_core;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          init_a, valid_a, last_a;
   logic [511:0]  blk_a;
   logic          init_b, valid_b, last_b;
   logic [1023:0] blk_b;

   // index 0..3 = 224, 256, 384, 512
   logic          rdy [4];
   logic          busy [4];
   logic [6:0]    rnd [4];
   logic          dv [4];
   logic [223:0]  d224;
   logic [255:0]  d256;
   logic [383:0]  d384;
   logic [511:0]  d512;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      int            dw;
      logic [1023:0] blk;
      logic [511:0]  dig;
      int            lat;
      string         name;
   } vec_t;

   typedef struct {
      int           dw;
      logic [511:0] dig;
      int           lat;
      string        name;
   } exp_t;

   vec_t vecs [4];
   exp_t sb [$];

   always #5 clk = ~clk;

   sha2_core #(.DigestWidth(224)) u_224 (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init_a), .block_i(blk_a), .block_valid_i(valid_a),
      .block_last_i(last_a), .block_ready_o(rdy[0]), .busy_o(busy[0]), .round_o(rnd[0]),
      .digest_o(d224), .digest_valid_o(dv[0]));
   sha2_core #(.DigestWidth(256)) u_256 (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init_a), .block_i(blk_a), .block_valid_i(valid_a),
      .block_last_i(last_a), .block_ready_o(rdy[1]), .busy_o(busy[1]), .round_o(rnd[1]),
      .digest_o(d256), .digest_valid_o(dv[1]));
   sha2_core #(.DigestWidth(384)) u_384 (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init_b), .block_i(blk_b), .block_valid_i(valid_b),
      .block_last_i(last_b), .block_ready_o(rdy[2]), .busy_o(busy[2]), .round_o(rnd[2]),
      .digest_o(d384), .digest_valid_o(dv[2]));
   sha2_core #(.DigestWidth(512)) u_512 (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init_b), .block_i(blk_b), .block_valid_i(valid_b),
      .block_last_i(last_b), .block_ready_o(rdy[3]), .busy_o(busy[3]), .round_o(rnd[3]),
      .digest_o(d512), .digest_valid_o(dv[3]));

   function automatic int idx(input int dw);
      case (dw)
         224:     return 0;
         256:     return 1;
         384:     return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [511:0] dig_of(input int i);
      case (i)
         0:       return 512'(d224);
         1:       return 512'(d256);
         2:       return 512'(d384);
         default: return d512;
      endcase
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int dw, input logic [1023:0] blk, input logic last, input logic valid);
      if (dw > 256) begin
         blk_b = blk; last_b = last; valid_b = valid;
      end else begin
         blk_a = blk[511:0]; last_a = last; valid_a = valid;
      end
   endtask

   // one-cycle handshake of a final block; expectation goes to the scoreboard
   task automatic send(input int dw, input logic [1023:0] blk, input logic [511:0] dig,
                       input int lat, input string name);
      drive(dw, blk, 1'b1, 1'b1);
      chk({name, ":ready"}, 512'(rdy[idx(dw)]), 512'd1);
      tick();
      drive(dw, blk, 1'b0, 1'b0);
      sb.push_back('{dw, dig, lat, name});
   endtask

   // pop the oldest expectation once its instance reports a digest
   task automatic wait_digest();
      exp_t e;
      int   n;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = sb.pop_front();
      n = 1;
      while (!dv[idx(e.dw)] && n < 400) begin
         tick();
         n++;
      end
      chk({e.name, ":digest"}, dig_of(idx(e.dw)), e.dig);
      chk({e.name, ":latency"}, 512'(n), 512'(e.lat));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0]  abc32;
      logic [1023:0] abc64;
      logic [511:0]  two1, two2;
      logic [511:0]  exp256, exp2blk;
      int            n, bad;

      abc32 = '0;
      abc32[511:480] = 32'h61626380;
      abc32[31:0]    = 32'h18;
      abc64 = '0;
      abc64[1023:992] = 32'h61626380;
      abc64[63:0]     = 64'h18;
      two1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
      two2 = 512'h1c0;
      exp256  = 512'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
      exp2blk = 512'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

      vecs[0] = '{256, 1024'(abc32), exp256, 66, "abc256"};
      vecs[1] = '{224, 1024'(abc32),
                  512'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 66, "abc224"};
      vecs[2] = '{512, abc64,
                  512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f,
                  82, "abc512"};
      vecs[3] = '{384, abc64,
                  512'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7,
                  82, "abc384"};

      rst_n = 1'b0;
      init_a = 1'b0; valid_a = 1'b0; last_a = 1'b0; blk_a = '0;
      init_b = 1'b0; valid_b = 1'b0; last_b = 1'b0; blk_b = '0;
      #3;
      // reset values
      for (int i = 1; i <= 3; i += 2) begin
         chk($sformatf("rst%0d:ready", i), 512'(rdy[i]), 512'd1);
         chk($sformatf("rst%0d:busy", i), 512'(busy[i]), 512'd0);
         chk($sformatf("rst%0d:round", i), 512'(rnd[i]), 512'd0);
         chk($sformatf("rst%0d:dvalid", i), 512'(dv[i]), 512'd0);
         chk($sformatf("rst%0d:digest", i), dig_of(i), 512'd0);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // single-block vectors for every variant
      for (int v = 0; v < 4; v++) begin
         send(vecs[v].dw, vecs[v].blk, vecs[v].dig, vecs[v].lat, vecs[v].name);
         chk({vecs[v].name, ":busy"}, 512'(busy[idx(vecs[v].dw)]), 512'd1);
         chk({vecs[v].name, ":round0"}, 512'(rnd[idx(vecs[v].dw)]), 512'd0);
         wait_digest();
      end

      // two-block message, second block held valid while busy
      drive(256, 1024'(two1), 1'b0, 1'b1);
      chk("2blk:ready1", 512'(rdy[1]), 512'd1);
      tick();
      drive(256, 1024'(two2), 1'b1, 1'b1);
      n = 1;
      bad = 0;
      while (!rdy[1] && n < 200) begin
         if (!busy[1] || dv[1]) bad++;
         tick();
         n++;
      end
      chk("2blk:busy_window", 512'(bad), 512'd0);
      chk("2blk:ready_return", 512'(n), 512'd66);
      sb.push_back('{256, exp2blk, 66, "2blk"});
      tick();
      drive(256, 1024'(two2), 1'b0, 1'b0);
      wait_digest();

      // abort at round 30 with a block offered in the same cycle
      drive(256, 1024'(abc32), 1'b1, 1'b1);
      tick();
      drive(256, 1024'(abc32), 1'b1, 1'b0);
      n = 0;
      while (rnd[1] != 7'd30 && n < 100) begin
         tick();
         n++;
      end
      chk("abort:round30", 512'(rnd[1]), 512'd30);
      init_a = 1'b1;
      drive(256, 1024'(abc32), 1'b1, 1'b1);
      #1;
      chk("abort:ready_low", 512'(rdy[1]), 512'd0);
      tick();
      init_a = 1'b0;
      drive(256, 1024'(abc32), 1'b0, 1'b0);
      chk("abort:busy", 512'(busy[1]), 512'd0);
      chk("abort:round", 512'(rnd[1]), 512'd0);
      chk("abort:dvalid", 512'(dv[1]), 512'd0);
      tick();
      tick();
      chk("abort:not_taken", 512'(busy[1]), 512'd0);
      send(256, 1024'(abc32), exp256, 66, "post_abort");
      wait_digest();

      // back-to-back message from DONE
      send(256, 1024'(abc32), exp256, 66, "b2b");
      chk("b2b:dv_drop", 512'(dv[1]), 512'd0);
      wait_digest();

      // asynchronous reset in the middle of HASH
      drive(256, 1024'(abc32), 1'b1, 1'b1);
      tick();
      drive(256, 1024'(abc32), 1'b0, 1'b0);
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      chk("arst:ready", 512'(rdy[1]), 512'd1);
      chk("arst:busy", 512'(busy[1]), 512'd0);
      chk("arst:round", 512'(rnd[1]), 512'd0);
      chk("arst:dvalid", 512'(dv[1]), 512'd0);
      chk("arst:digest", dig_of(1), 512'd0);
      chk("arst:digest512", dig_of(3), 512'd0);
      #2;
      rst_n = 1'b1;
      tick();
      send(256, 1024'(abc32), exp256, 66, "post_rst");
      wait_digest();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sha2_core.md
# sha2_core

Parametrised SHA-2 compression engine covering SHA-224, SHA-256, SHA-384 and SHA-512 from one RTL source. It is the successor to the fixed 256/224 core. Changes from that core:
- A valid/ready block handshake and an explicit last-block flag replace enable/hold control and in-band 0x80 end-of-message detection.
- A parameter selects 32- or 64-bit word datapaths.

The block sits behind the register interface. Padding and length encoding are done upstream; this core only compresses pre-padded blocks.

## Interface
Parameters:
- DigestWidth, 256, digest size; legal values 224, 256, 384, 512 (elaboration error otherwise).
- WordWidth, derived, 64 if DigestWidth > 256, else 32.
- BlockWidth, derived, 16*WordWidth (512 or 1024).
- Rounds, derived, 80 if WordWidth == 64, else 64.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- init_i  in  1  abort any work and restart a message from the IV; one-cycle pulse.
- block_i  in  BlockWidth  padded message block; word 0 is in the MSBs, big-endian.
- block_valid_i  in  1  block_i is valid.
- block_last_i  in  1  qualifies block_i as the final block of the message.
- block_ready_o  out  1  the core accepts a block this cycle.
- busy_o  out  1  a compression is in progress.
- round_o  out  7  current round index, 0..Rounds-1.
- digest_o  out  DigestWidth  final digest: the leftmost DigestWidth bits of H0..H7.
- digest_valid_o  out  1  digest_o holds the result of the last completed message.

## Operation
- FSM states: IDLE, HASH, FINAL, DONE.
- **IDLE**
  - Chaining registers H0..H7 hold the IV for the selected variant.
  - block_ready_o = ~init_i.
  - On a handshake (valid & ready): capture block_i into the 16-word schedule window, load a..h from H, latch block_last_i, round = 0, go to HASH.
- **HASH**
  - One round per cycle. W[t] comes from the window for t < 16; otherwise W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], written back into the window in place.
  - σ/Σ rotate amounts follow FIPS 180-4 for the selected WordWidth.
  - After round Rounds-1, go to FINAL.
- **FINAL**
  - H[i] += working variable i, modulo 2^WordWidth.
  - If the latched last flag is 1: go to DONE.
  - If it is 0: go to IDLE with H kept (no IV reload).
  - digest_valid_o stays 0 until DONE.
- **DONE**
  - digest_valid_o = 1; digest_o is stable.
  - block_ready_o = ~init_i.
  - On a handshake, reload the IV, start a new message (digest_valid_o drops the next cycle), then behave as in the IDLE acceptance above.
- **init_i**
  - Highest priority in every state.
  - Next cycle: state = IDLE, H = IV, round = 0, digest_valid_o = 0.
  - A block presented in the same cycle as init_i is not accepted.
- busy_o = (state is HASH or FINAL).
- round_o = round counter; it holds 0 outside HASH.

## Timing
- Reset values:
  - state IDLE, H = IV, a..h = 0, schedule window = 0, round 0.
  - digest_o = 0 (digest register cleared), digest_valid_o = 0, busy_o = 0.
  - block_ready_o = 1 (unless init_i is asserted).
- Per-block cost: handshake at cycle t; rounds occupy cycles t+1..t+Rounds; FINAL at t+Rounds+1; block_ready_o is high again at t+Rounds+2.
- Throughput: one block per Rounds+2 cycles (66 for 32-bit words, 82 for 64-bit).
- Last block: digest_valid_o rises at t+Rounds+2, registered.
- block_valid_i may be held indefinitely. block_i and block_last_i need only be stable during the handshake cycle.
- Reset mid-HASH: asynchronous return to the reset values listed above. No partial digest is retained.

## Structure
- Shared package sha2_pkg holds:
  - fsm enum sha2_fsm_e;
  - K256[64] and K512[80] constant tables;
  - IV tables for the four variants;
  - Σ0/Σ1/σ0/σ1 and Ch/Maj functions, parametrised on word width.
- One sub-module, sha2_msg_sched:
  - 16-word sliding window with load and advance;
  - outputs W[t] for the current round.
- The top level contains the FSM, the round datapath, the chaining registers and the handshake.

## Test plan
- **SHA-256 "abc".** Stimulus: DigestWidth=256, single padded block, last=1. Response: digest_o = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with digest_valid_o rising exactly 66 cycles after the handshake.
- **SHA-224 "abc".** Stimulus: DigestWidth=224, single padded block, last=1. Response: digest_o = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7.
- **SHA-512 and SHA-384 "abc".** Stimulus: DigestWidth=512 and 384, single padded block each. Responses:
  - 512: ddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f
  - 384: cb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7
  - Both: 82-cycle latency.
- **Two-block message with backpressure.** Stimulus: SHA-256 of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with block 2 presented while busy. Response: block_ready_o stays 0 until FINAL has passed; no block is lost; digest_o = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- **Abort with init_i.** Stimulus: init_i pulse at round 30 of block 1, with block_valid_i also high in that cycle. Response: block not accepted; busy_o = 0 and round_o = 0 next cycle; a fresh "abc" then yields the correct digest.
- **Back-to-back messages and reset.** Stimulus: from DONE, hand in a new "abc" block. Response: digest_valid_o drops the next cycle and returns with an identical digest. Separately, rst_ni asserted mid-HASH → all outputs return to their reset values within the same cycle.
